// File: rtl/controle_comparador_mag_pkg.sv
// Shared definitions for the frame max/min sequencer: state encoding and default geometry.
package controle_comparador_mag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrlState_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_N     = 8;

endpackage

// File: rtl/controle_comparador_mag_comparador.sv
// Unsigned magnitude comparator reused every cycle by the sequencer.
module comparador_mag_param #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/controle_comparador_mag.sv
// Streams a frame of N samples through two shared comparators and reports the
// frame maximum/minimum plus the index of the first occurrence of each.
module controle_comparador_mag
  import controle_comparador_mag_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N = DEF_N,
  localparam int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [IDXW-1:0] max_idx,
  output logic [IDXW-1:0] min_idx,
  output logic            busy
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  ctrlState_t      stateReg;
  logic [IDXW-1:0] cntReg;
  logic [WIDTH-1:0] maxValReg, minValReg;
  logic [IDXW-1:0] maxIdxReg, minIdxReg;
  logic            inReadyReg, outValidReg, busyReg;

  logic gtMax, ltMin;
  logic unusedEqA, unusedLtA, unusedEqB, unusedGtB;

  comparador_mag_param #(.WIDTH(WIDTH)) compMax (
    .a (in_data),
    .b (maxValReg),
    .eq(unusedEqA),
    .gt(gtMax),
    .lt(unusedLtA)
  );

  comparador_mag_param #(.WIDTH(WIDTH)) compMin (
    .a (in_data),
    .b (minValReg),
    .eq(unusedEqB),
    .gt(unusedGtB),
    .lt(ltMin)
  );

  // Handshake flags are registered together with the state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      cntReg      <= '0;
      maxValReg   <= '0;
      minValReg   <= '0;
      maxIdxReg   <= '0;
      minIdxReg   <= '0;
      inReadyReg  <= 1'b0;
      outValidReg <= 1'b0;
      busyReg     <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (start) begin
            stateReg   <= RUN;
            cntReg     <= '0;
            inReadyReg <= 1'b1;
            busyReg    <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            // Abort wins over a sample offered in the same cycle.
            stateReg   <= IDLE;
            cntReg     <= '0;
            inReadyReg <= 1'b0;
            busyReg    <= 1'b0;
          end else if (in_valid) begin
            if (cntReg == '0) begin
              maxValReg <= in_data;
              minValReg <= in_data;
              maxIdxReg <= '0;
              minIdxReg <= '0;
            end else begin
              // Strict compares keep the earliest index on ties.
              if (gtMax) begin
                maxValReg <= in_data;
                maxIdxReg <= cntReg;
              end
              if (ltMin) begin
                minValReg <= in_data;
                minIdxReg <= cntReg;
              end
            end
            if (cntReg == LAST_IDX) begin
              stateReg    <= DONE;
              cntReg      <= '0;
              inReadyReg  <= 1'b0;
              outValidReg <= 1'b1;
            end else begin
              cntReg <= cntReg + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            stateReg    <= IDLE;
            outValidReg <= 1'b0;
            busyReg     <= 1'b0;
          end
        end
        default: begin
          stateReg    <= IDLE;
          cntReg      <= '0;
          inReadyReg  <= 1'b0;
          outValidReg <= 1'b0;
          busyReg     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = inReadyReg;
  assign out_valid = outValidReg;
  assign busy      = busyReg;
  assign max_val   = maxValReg;
  assign min_val   = minValReg;
  assign max_idx   = maxIdxReg;
  assign min_idx   = minIdxReg;

endmodule

// File: tb/tb_controle_comparador_mag.sv
// Directed table-driven bench for the frame max/min sequencer.
module tb_controle_comparador_mag;

  localparam int WIDTH = 4;
  localparam int N = 8;
  localparam int IDXW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic in_ready, out_valid, busy;
  logic [WIDTH-1:0] max_val, min_val;
  logic [IDXW-1:0] max_idx, min_idx;

  int checks = 0;
  int errors = 0;

  controle_comparador_mag #(.WIDTH(WIDTH), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .max_val  (max_val),
    .min_val  (min_val),
    .max_idx  (max_idx),
    .min_idx  (min_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s [N];
    bit gaps;
    bit startInRun;
    int hold;
    bit abortInDone;
    bit startOnRelease;
    logic [WIDTH-1:0] expMax;
    logic [WIDTH-1:0] expMin;
    logic [IDXW-1:0] expMaxIdx;
    logic [IDXW-1:0] expMinIdx;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chkResult(input string tag, input int v);
    chk({tag, "_max_val"}, 32'(max_val), 32'(vecs[v].expMax));
    chk({tag, "_min_val"}, 32'(min_val), 32'(vecs[v].expMin));
    chk({tag, "_max_idx"}, 32'(max_idx), 32'(vecs[v].expMaxIdx));
    chk({tag, "_min_idx"}, 32'(min_idx), 32'(vecs[v].expMinIdx));
  endtask

  task automatic runVec(input int v);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run_busy", 32'(busy), 1);
    chk("run_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < N; i++) begin
      if (vecs[v].gaps && i > 0) begin
        in_valid = 1'b0;
        step();
        chk("gap_no_early_valid", 32'(out_valid), 0);
      end
      in_valid = 1'b1;
      in_data  = vecs[v].s[i];
      start    = vecs[v].startInRun && (i == 3);
      step();
      start = 1'b0;
      if (i < N - 1) chk("run_no_early_valid", 32'(out_valid), 0);
    end
    in_valid = 1'b0;
    chk("done_out_valid", 32'(out_valid), 1);
    chk("done_in_ready", 32'(in_ready), 0);
    chk("done_busy", 32'(busy), 1);
    chkResult($sformatf("vec%0d", v), v);
    for (int h = 0; h < vecs[v].hold; h++) begin
      abort = vecs[v].abortInDone;
      step();
      chk("hold_out_valid", 32'(out_valid), 1);
      chkResult($sformatf("vec%0d_hold%0d", v, h), v);
    end
    abort     = 1'b0;
    out_ready = 1'b1;
    start     = vecs[v].startOnRelease;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("release_out_valid", 32'(out_valid), 0);
    chk("release_busy", 32'(busy), 0);
    chk("release_keep_max", 32'(max_val), 32'(vecs[v].expMax));
    if (vecs[v].startOnRelease) begin
      step();
      chk("start_on_release_ignored", 32'(busy), 0);
    end
  endtask

  initial begin
    vecs[0] = '{s: '{3, 9, 1, 9, 0, 15, 7, 0}, gaps: 0, startInRun: 0, hold: 0, abortInDone: 0,
                startOnRelease: 0, expMax: 15, expMin: 0, expMaxIdx: 5, expMinIdx: 4};
    vecs[1] = '{s: '{5, 5, 5, 5, 5, 5, 5, 5}, gaps: 0, startInRun: 0, hold: 0, abortInDone: 0,
                startOnRelease: 1, expMax: 5, expMin: 5, expMaxIdx: 0, expMinIdx: 0};
    vecs[2] = '{s: '{0, 15, 15, 0, 7, 7, 7, 7}, gaps: 0, startInRun: 1, hold: 0, abortInDone: 0,
                startOnRelease: 0, expMax: 15, expMin: 0, expMaxIdx: 1, expMinIdx: 0};
    vecs[3] = '{s: '{1, 2, 3, 4, 5, 6, 7, 8}, gaps: 0, startInRun: 0, hold: 3, abortInDone: 1,
                startOnRelease: 0, expMax: 8, expMin: 1, expMaxIdx: 7, expMinIdx: 0};
    vecs[4] = '{s: '{8, 7, 6, 5, 4, 3, 2, 1}, gaps: 1, startInRun: 0, hold: 0, abortInDone: 0,
                startOnRelease: 0, expMax: 8, expMin: 1, expMaxIdx: 0, expMinIdx: 7};

    // Reset state
    #3;
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_max_val", 32'(max_val), 0);
    chk("reset_min_val", 32'(min_val), 0);
    chk("reset_max_idx", 32'(max_idx), 0);
    chk("reset_min_idx", 32'(min_idx), 0);
    #9 rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 0);

    for (int v = 0; v < 5; v++) runVec(v);

    // Abort after three accepts; the sample offered with abort is discarded
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 4'd2; step();
    in_data = 4'd4; step();
    in_data = 4'd1; step();
    in_data = 4'd15;
    abort = 1'b1;
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_in_ready", 32'(in_ready), 0);
    chk("abort_discard_max", 32'(max_val), 4);
    chk("abort_min", 32'(min_val), 1);
    step();
    step();
    chk("abort_stays_idle", 32'(out_valid), 0);

    // Asynchronous reset between clock edges in the middle of a frame
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 4'd9;  step();
    in_data = 4'd3;  step();
    in_data = 4'd12; step();
    in_data = 4'd6;  step();
    in_valid = 1'b0;
    chk("prereset_max_val", 32'(max_val), 12);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_max_val", 32'(max_val), 0);
    chk("areset_min_val", 32'(min_val), 0);
    chk("areset_max_idx", 32'(max_idx), 0);
    chk("areset_min_idx", 32'(min_idx), 0);
    chk("areset_busy", 32'(busy), 0);
    chk("areset_in_ready", 32'(in_ready), 0);
    chk("areset_out_valid", 32'(out_valid), 0);
    #3 rst_n = 1'b1;
    step();
    runVec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
